// File: rtl/uart_rx.sv
// uart_rx: asynchronous serial receiver.
// It receives idle-high frames made of one start bit (0), WIDTH data bits sent
// LSB first and one stop bit (1). Each bit lasts DIVISOR clk cycles.
// The receiver samples every bit at its midpoint. A good word is presented on
// o_data together with a one-cycle o_dv strobe. A low stop bit gives a
// one-cycle o_frame_err strobe instead.
// The receiver waits in BREAK until the line returns high before it looks for
// another start bit.
// DIVISOR must be even and >= 4, and must match the transmitter.

module uart_rx #(
    parameter int WIDTH   = 8,
    parameter int DIVISOR = 100
) (
    input  logic             clk,
    input  logic             i_reset_n,
    input  logic             i_rx,
    output logic [WIDTH-1:0] o_data,
    output logic             o_dv,
    output logic             o_frame_err,
    output logic             o_busy
);

    localparam int CNT_W = $clog2(DIVISOR);
    localparam int SC_W  = $clog2(WIDTH + 1);

    // Bit-timer terminal counts.
    // START ends at half a bit, so every later sample falls at mid-bit.
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(DIVISOR / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(DIVISOR - 1);
    localparam logic [SC_W-1:0]  LAST_S  = SC_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t             state;
    logic               rx_meta;
    logic               rx_s;
    logic [CNT_W-1:0]   bit_cnt;
    logic [SC_W-1:0]    s_cnt;
    logic [WIDTH-1:0]   shreg;
    logic               dv_pend;
    logic               err_pend;

    // Two-flop synchroniser for the asynchronous serial line.
    // NOTE: both flops reset to 1 (idle level), so a reset does not fake a start bit.
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments let rx_s take the old rx_meta, which forms a true two-stage chain.
            rx_meta <= i_rx;
            rx_s    <= rx_meta;
        end
    end

    // Frame FSM with bit timer, data shifter and registered output strobes.
    // The stop-bit verdict is held for one cycle in dv_pend/err_pend.
    // o_data and its strobe are then loaded together on the following edge.
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state       <= S_IDLE;
            bit_cnt     <= '0;
            s_cnt       <= '0;
            shreg       <= '0;
            dv_pend     <= 1'b0;
            err_pend    <= 1'b0;
            o_data      <= '0;
            o_dv        <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            dv_pend     <= 1'b0;
            err_pend    <= 1'b0;
            o_dv        <= dv_pend;
            o_frame_err <= err_pend;
            if (dv_pend) begin
                o_data <= shreg;
            end

            case (state)
                S_IDLE: begin
                    if (!rx_s) begin
                        state   <= S_START;
                        bit_cnt <= '0;
                    end
                end

                S_START: begin
                    if (bit_cnt == HALF_M1) begin
                        bit_cnt <= '0;
                        if (rx_s) begin
                            // Line went high again before mid-start: treat it as a glitch.
                            state <= S_IDLE;
                        end else begin
                            state <= S_DATA;
                            s_cnt <= '0;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end

                S_DATA: begin
                    if (bit_cnt == FULL_M1) begin
                        bit_cnt <= '0;
                        shreg   <= {rx_s, shreg[WIDTH-1:1]};
                        s_cnt   <= s_cnt + SC_W'(1);
                        if (s_cnt == LAST_S) begin
                            state <= S_STOP;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end

                S_STOP: begin
                    if (bit_cnt == FULL_M1) begin
                        bit_cnt <= '0;
                        // Leave STOP at mid-stop-bit, so a start bit that follows at once is still caught.
                        if (rx_s) begin
                            dv_pend <= 1'b1;
                            state   <= S_IDLE;
                        end else begin
                            err_pend <= 1'b1;
                            state    <= S_BREAK;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end

                S_BREAK: begin
                    if (rx_s) begin
                        state   <= S_IDLE;
                        bit_cnt <= '0;
                    end
                end

                default: begin
                    state   <= S_IDLE;
                    bit_cnt <= '0;
                end
            endcase
        end
    end

    // Busy is a decode of the registered state: high only while a frame is in progress.
    assign o_busy = (state == S_START) || (state == S_DATA) || (state == S_STOP);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed testbench for uart_rx with WIDTH=8 and DIVISOR=16.
// A negedge monitor records every strobe with its cycle number.
// The scenario tasks compare those records against hand-computed values.

module tb_uart_rx;

    localparam int WIDTH   = 8;
    localparam int DIVISOR = 16;
    // Cycles from driving the start bit (at a negedge) to o_dv being visible:
    // 2 sync stages + 1 cycle to enter START + DIVISOR/2 + (WIDTH+1)*DIVISOR + 1.
    localparam int LAT     = 3 + DIVISOR / 2 + (WIDTH + 1) * DIVISOR + 1;
    localparam int FRAME   = (WIDTH + 2) * DIVISOR;

    logic             clk;
    logic             i_reset_n;
    logic             i_rx;
    logic [WIDTH-1:0] o_data;
    logic             o_dv;
    logic             o_frame_err;
    logic             o_busy;

    int               cyc;
    int               errors;
    int               checks;
    int               dv_cyc[$];
    logic [WIDTH-1:0] dv_data[$];
    int               err_cyc[$];

    uart_rx #(.WIDTH(WIDTH), .DIVISOR(DIVISOR)) dut (
        .clk         (clk),
        .i_reset_n   (i_reset_n),
        .i_rx        (i_rx),
        .o_data      (o_data),
        .o_dv        (o_dv),
        .o_frame_err (o_frame_err),
        .o_busy      (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record each strobe at the negedge, away from the active edge.
    always @(negedge clk) begin
        if (o_dv) begin
            dv_cyc.push_back(cyc);
            dv_data.push_back(o_data);
        end
        if (o_frame_err) begin
            err_cyc.push_back(cyc);
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_log();
        dv_cyc.delete();
        dv_data.delete();
        err_cyc.delete();
    endtask

    // Drive one frame. The caller is at a negedge and is back at a negedge on return.
    task automatic send_frame(input logic [WIDTH-1:0] d, input logic stop_bit, output int c0);
        c0   = cyc;
        i_rx = 1'b0;
        idle(DIVISOR);
        for (int i = 0; i < WIDTH; i++) begin
            i_rx = d[i];
            idle(DIVISOR);
        end
        i_rx = stop_bit;
        idle(DIVISOR);
    endtask

    task automatic test_reset();
        i_reset_n = 1'b0;
        i_rx      = 1'b1;
        idle(3);
        checks++;
        if ({o_data, o_dv, o_frame_err, o_busy} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got data=%h dv=%b err=%b busy=%b, want all 0",
                     o_data, o_dv, o_frame_err, o_busy);
        end
        i_reset_n = 1'b1;
        idle(5);
        checks++;
        if (o_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_busy: got %b want 0", o_busy);
        end
    endtask

    task automatic test_single();
        int c0;
        clear_log();
        send_frame(8'hA5, 1'b1, c0);
        idle(20);
        checks++;
        if (dv_cyc.size() != 1 || dv_data[0] !== 8'hA5) begin
            errors++;
            $display("FAIL single_dv: got %0d pulses data=%h, want 1 pulse data=a5",
                     dv_cyc.size(), (dv_data.size() > 0) ? dv_data[0] : 8'hxx);
        end
        checks++;
        if (dv_cyc.size() < 1 || dv_cyc[0] != c0 + LAT) begin
            errors++;
            $display("FAIL single_latency: got cycle %0d want %0d",
                     (dv_cyc.size() > 0) ? dv_cyc[0] : -1, c0 + LAT);
        end
        checks++;
        if (err_cyc.size() != 0) begin
            errors++;
            $display("FAIL single_no_err: got %0d frame errors want 0", err_cyc.size());
        end
    endtask

    task automatic test_back_to_back();
        int ca;
        int cb;
        clear_log();
        send_frame(8'h00, 1'b1, ca);
        send_frame(8'hFF, 1'b1, cb);
        idle(20);
        checks++;
        if (dv_cyc.size() != 2 || dv_data[0] !== 8'h00 || dv_data[1] !== 8'hFF) begin
            errors++;
            $display("FAIL b2b_data: got %0d pulses, want 2 pulses 00 then ff", dv_cyc.size());
        end
        checks++;
        if (dv_cyc.size() != 2 || dv_cyc[1] - dv_cyc[0] != FRAME) begin
            errors++;
            $display("FAIL b2b_spacing: got %0d want %0d",
                     (dv_cyc.size() == 2) ? dv_cyc[1] - dv_cyc[0] : -1, FRAME);
        end
        checks++;
        if (err_cyc.size() != 0) begin
            errors++;
            $display("FAIL b2b_no_err: got %0d want 0", err_cyc.size());
        end
    endtask

    task automatic test_glitch();
        clear_log();
        i_rx = 1'b0;
        idle(4);
        checks++;
        if (o_busy !== 1'b1) begin
            errors++;
            $display("FAIL glitch_busy: got %b want 1", o_busy);
        end
        i_rx = 1'b1;
        idle(30);
        checks++;
        if (o_busy !== 1'b0 || dv_cyc.size() != 0 || err_cyc.size() != 0) begin
            errors++;
            $display("FAIL glitch_reject: got busy=%b dv=%0d err=%0d want 0/0/0",
                     o_busy, dv_cyc.size(), err_cyc.size());
        end
    endtask

    task automatic test_frame_error();
        int c0;
        int c1;
        clear_log();
        send_frame(8'h3C, 1'b1, c0);
        idle(10);
        send_frame(8'h81, 1'b0, c1);
        idle(40);
        checks++;
        if (err_cyc.size() != 1 || err_cyc[0] != c1 + LAT) begin
            errors++;
            $display("FAIL ferr_pulse: got %0d pulses at %0d, want 1 at %0d",
                     err_cyc.size(), (err_cyc.size() > 0) ? err_cyc[0] : -1, c1 + LAT);
        end
        checks++;
        if (o_data !== 8'h3C) begin
            errors++;
            $display("FAIL ferr_data_hold: got %h want 3c", o_data);
        end
        checks++;
        if (o_busy !== 1'b0) begin
            errors++;
            $display("FAIL ferr_break_busy: got %b want 0", o_busy);
        end
        i_rx = 1'b1;
        idle(10);
        send_frame(8'h42, 1'b1, c0);
        idle(20);
        checks++;
        if (dv_cyc.size() != 2 || dv_data[0] !== 8'h3C || dv_data[1] !== 8'h42) begin
            errors++;
            $display("FAIL ferr_recover: got %0d pulses, want 2 pulses 3c then 42", dv_cyc.size());
        end
        checks++;
        if (err_cyc.size() != 1) begin
            errors++;
            $display("FAIL ferr_count: got %0d want 1", err_cyc.size());
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [WIDTH-1:0] d;
        int               c0;
        d = 8'hC3;
        clear_log();
        i_rx = 1'b0;
        idle(DIVISOR);
        for (int i = 0; i < 4; i++) begin
            i_rx = d[i];
            idle(DIVISOR);
        end
        i_rx = d[4];
        idle(DIVISOR / 2);
        checks++;
        if (o_busy !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_busy_before: got %b want 1", o_busy);
        end
        i_reset_n = 1'b0;
        #1;
        checks++;
        if ({o_data, o_dv, o_frame_err, o_busy} !== '0) begin
            errors++;
            $display("FAIL rstmid_outputs: got data=%h dv=%b err=%b busy=%b, want all 0",
                     o_data, o_dv, o_frame_err, o_busy);
        end
        i_rx = 1'b1;
        idle(5);
        i_reset_n = 1'b1;
        idle(40);
        send_frame(8'h5A, 1'b1, c0);
        idle(20);
        checks++;
        if (dv_cyc.size() != 1 || dv_data[0] !== 8'h5A || err_cyc.size() != 0) begin
            errors++;
            $display("FAIL rstmid_next: got dv=%0d err=%0d, want one 5a and no error",
                     dv_cyc.size(), err_cyc.size());
        end
    endtask

    task automatic test_loopback();
        logic [WIDTH-1:0] exp_q[$];
        logic [WIDTH-1:0] w;
        int               c0;
        int               bad;
        clear_log();
        for (int i = 0; i < 256; i++) begin
            w = WIDTH'($urandom_range(0, 255));
            exp_q.push_back(w);
            send_frame(w, 1'b1, c0);
        end
        idle(20);
        checks++;
        if (dv_cyc.size() != 256 || err_cyc.size() != 0) begin
            errors++;
            $display("FAIL loop_count: got dv=%0d err=%0d want 256/0", dv_cyc.size(), err_cyc.size());
        end
        bad = 0;
        for (int i = 0; i < 256 && i < dv_data.size(); i++) begin
            if (dv_data[i] !== exp_q[i]) begin
                bad++;
                if (bad <= 5) begin
                    $display("FAIL loop_word[%0d]: got %h want %h", i, dv_data[i], exp_q[i]);
                end
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL loop_order: %0d words differ, want 0", bad);
        end
    endtask

    initial begin
        cyc    = 0;
        errors = 0;
        checks = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_frame_error();
        test_reset_mid_frame();
        test_loopback();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
